// File: rtl/temac_miim_master_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// temac_miim_master_if : host-side MIIM request/response bundle (rev 1.0)
// HOSTPRESUP exists only when TEMAC_MIIM_PRESUP_EN is defined.
// ---------------------------------------------------------------------------
interface temac_miim_master_if #(
   parameter int NUM_CH = 2
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic            HOSTREQ;
   logic            HOSTMIIMSEL;
   logic [1:0]      HOSTOPCODE;
   logic [9:0]      HOSTADDR;
   logic [CH_W-1:0] HOSTCHSEL;
   logic [15:0]     HOSTWRDATA;
   logic            HOSTMIIMRDY;
   logic [15:0]     HOSTRDDATA;
   logic            HOSTMIIMERR;
`ifdef TEMAC_MIIM_PRESUP_EN
   logic            HOSTPRESUP;
`endif

   modport master (
      output HOSTREQ, HOSTMIIMSEL, HOSTOPCODE, HOSTADDR, HOSTCHSEL, HOSTWRDATA,
`ifdef TEMAC_MIIM_PRESUP_EN
      output HOSTPRESUP,
`endif
      input  HOSTMIIMRDY, HOSTRDDATA, HOSTMIIMERR
   );

   modport slave (
      input  HOSTREQ, HOSTMIIMSEL, HOSTOPCODE, HOSTADDR, HOSTCHSEL, HOSTWRDATA,
`ifdef TEMAC_MIIM_PRESUP_EN
      input  HOSTPRESUP,
`endif
      output HOSTMIIMRDY, HOSTRDDATA, HOSTMIIMERR
   );
endinterface
`default_nettype wire

// File: rtl/temac_miim_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// temac_miim_master : clause-22 MDIO master over NUM_CH PHY ports (rev 1.0)
// Optional preamble suppression via TEMAC_MIIM_PRESUP_EN.
// ---------------------------------------------------------------------------
module temac_miim_master #(
   parameter int NUM_CH       = 2,
   parameter int CLK_DIV      = 10,
   parameter int PREAMBLE_LEN = 32
) (
   input  wire logic              HOSTCLK,
   input  wire logic              RESET,
   temac_miim_master_if.slave     host,
   output logic [NUM_CH-1:0]      PHYMDC,
   output logic [NUM_CH-1:0]      PHYMDOUT,
   output logic [NUM_CH-1:0]      PHYMDTRI,
   input  wire logic [NUM_CH-1:0] PHYMDIN
);
   localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int              DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [5:0]      PRE_LAST = 6'(PREAMBLE_LEN - 1);
   localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(NUM_CH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRE   = 2'd1,
      S_FRAME = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [5:0]        bit_q, bit_d;
   logic              mdc_q, mdc_d;
   logic              mdo_q, mdo_d;
   logic              tri_q, tri_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              rd_op_q, rd_op_d;
   logic [31:0]       frame_q, frame_d;
   logic [15:0]       rsh_q, rsh_d;
   logic              ta_err_q, ta_err_d;
   logic              rdy_q, rdy_d;
   logic [15:0]       rddata_q, rddata_d;
   logic              err_q, err_d;
   logic [NUM_CH-1:0] phy_mdc_q, phy_mdc_d;
   logic [NUM_CH-1:0] phy_mdo_q, phy_mdo_d;
   logic [NUM_CH-1:0] phy_tri_q, phy_tri_d;

   logic              w_presup;
   logic              w_valid_op;
   logic              w_req;
   logic              w_ch_ok;
   logic              w_mdin;
   logic              w_is_rd;
   logic [31:0]       w_frame;

`ifdef TEMAC_MIIM_PRESUP_EN
   assign w_presup = host.HOSTPRESUP;
`else
   assign w_presup = 1'b0;
`endif

   assign w_valid_op = (host.HOSTOPCODE == 2'b01) || (host.HOSTOPCODE == 2'b10);
   assign w_req      = host.HOSTREQ & host.HOSTMIIMSEL & rdy_q & w_valid_op;
   assign w_ch_ok    = ({1'b0, host.HOSTCHSEL} < CH_LIMIT);
   assign w_mdin     = PHYMDIN[ch_q];
   assign w_is_rd    = host.HOSTOPCODE[1];
   // Reads park TA/DATA at 1; those bits go out while MDIO is released.
   assign w_frame    = {2'b01, host.HOSTOPCODE, host.HOSTADDR,
                        w_is_rd ? 2'b11 : 2'b10,
                        w_is_rd ? 16'hFFFF : host.HOSTWRDATA};

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      mdc_d     = mdc_q;
      mdo_d     = mdo_q;
      tri_d     = tri_q;
      ch_d      = ch_q;
      rd_op_d   = rd_op_q;
      frame_d   = frame_q;
      rsh_d     = rsh_q;
      ta_err_d  = ta_err_q;
      rdy_d     = rdy_q;
      rddata_d  = rddata_q;
      err_d     = err_q;
      phy_mdc_d = '0;
      phy_mdo_d = '1;
      phy_tri_d = '1;

      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               if (w_ch_ok) begin
                  ch_d     = host.HOSTCHSEL;
                  rd_op_d  = w_is_rd;
                  frame_d  = w_frame;
                  rsh_d    = '0;
                  ta_err_d = 1'b0;
                  div_d    = '0;
                  bit_d    = '0;
                  mdc_d    = 1'b0;
                  tri_d    = 1'b0;
                  rdy_d    = 1'b0;
                  err_d    = 1'b0;
                  if (w_presup) begin
                     state_d = S_FRAME;
                     mdo_d   = w_frame[31];
                  end else begin
                     state_d = S_PRE;
                     mdo_d   = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + 1'b1;
            end else begin
               div_d = '0;
               if (!mdc_q) begin
                  // Rising MDC edge: PHY data is sampled here.
                  mdc_d = 1'b1;
                  if ((state_q == S_FRAME) && rd_op_q) begin
                     if (bit_q == 6'd15) ta_err_d = w_mdin;
                     if (bit_q >= 6'd16) rsh_d = {rsh_q[14:0], w_mdin};
                  end
               end else begin
                  mdc_d = 1'b0;
                  if (state_q == S_PRE) begin
                     if (bit_q == PRE_LAST) begin
                        state_d = S_FRAME;
                        bit_d   = '0;
                        mdo_d   = frame_q[31];
                     end else begin
                        bit_d = bit_q + 1'b1;
                     end
                  end else if (bit_q == 6'd31) begin
                     state_d = S_IDLE;
                     bit_d   = '0;
                     rdy_d   = 1'b1;
                     mdo_d   = 1'b1;
                     tri_d   = 1'b1;
                     if (rd_op_q) begin
                        rddata_d = rsh_q;
                        err_d    = ta_err_q;
                     end
                  end else begin
                     bit_d   = bit_q + 1'b1;
                     frame_d = {frame_q[30:0], 1'b1};
                     mdo_d   = frame_q[30];
                     // Bit 14 is TA[0]: reads hand MDIO to the PHY from here.
                     if (rd_op_q && (bit_q == 6'd13)) tri_d = 1'b1;
                  end
               end
            end
         end
      endcase

      for (int i = 0; i < NUM_CH; i++) begin
         if ((state_d != S_IDLE) && (ch_d == CH_W'(i))) begin
            phy_mdc_d[i] = mdc_d;
            phy_mdo_d[i] = mdo_d;
            phy_tri_d[i] = tri_d;
         end
      end
   end

   always_ff @(posedge HOSTCLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         mdc_q     <= 1'b0;
         mdo_q     <= 1'b1;
         tri_q     <= 1'b1;
         ch_q      <= '0;
         rd_op_q   <= 1'b0;
         frame_q   <= '0;
         rsh_q     <= '0;
         ta_err_q  <= 1'b0;
         rdy_q     <= 1'b1;
         rddata_q  <= '0;
         err_q     <= 1'b0;
         phy_mdc_q <= '0;
         phy_mdo_q <= '1;
         phy_tri_q <= '1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         mdc_q     <= mdc_d;
         mdo_q     <= mdo_d;
         tri_q     <= tri_d;
         ch_q      <= ch_d;
         rd_op_q   <= rd_op_d;
         frame_q   <= frame_d;
         rsh_q     <= rsh_d;
         ta_err_q  <= ta_err_d;
         rdy_q     <= rdy_d;
         rddata_q  <= rddata_d;
         err_q     <= err_d;
         phy_mdc_q <= phy_mdc_d;
         phy_mdo_q <= phy_mdo_d;
         phy_tri_q <= phy_tri_d;
      end
   end

   assign host.HOSTMIIMRDY = rdy_q;
   assign host.HOSTRDDATA  = rddata_q;
   assign host.HOSTMIIMERR = err_q;
   assign PHYMDC           = phy_mdc_q;
   assign PHYMDOUT         = phy_mdo_q;
   assign PHYMDTRI         = phy_tri_q;
endmodule
`default_nettype wire

// File: tb/tb_temac_miim_master.sv
`default_nettype none
// tb_temac_miim_master: scoreboard-checked MIIM frames on a 2-port instance,
// plus channel-range and short-preamble checks on a 3-port instance.
module tb_temac_miim_master;
   localparam int NUM_CH  = 2;
   localparam int CLK_DIV = 4;
   localparam int PRE     = 32;
   localparam int BIT_CYC = 2 * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mdc, mdout, mdtri;
   logic [1:0] mdin = 2'b11;
   logic [2:0] mdc3, mdout3, mdtri3;
   logic [2:0] mdin3 = 3'b111;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   temac_miim_master_if #(.NUM_CH(NUM_CH)) bus ();
   temac_miim_master_if #(.NUM_CH(3))      bus3 ();

   temac_miim_master #(.NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .PREAMBLE_LEN(PRE)) dut (
      .HOSTCLK (clk),
      .RESET   (rst),
      .host    (bus),
      .PHYMDC  (mdc),
      .PHYMDOUT(mdout),
      .PHYMDTRI(mdtri),
      .PHYMDIN (mdin)
   );

   temac_miim_master #(.NUM_CH(3), .CLK_DIV(2), .PREAMBLE_LEN(1)) dut3 (
      .HOSTCLK (clk),
      .RESET   (rst),
      .host    (bus3),
      .PHYMDC  (mdc3),
      .PHYMDOUT(mdout3),
      .PHYMDTRI(mdtri3),
      .PHYMDIN (mdin3)
   );

   typedef struct {
      logic [63:0] out;
      logic [63:0] tri_m;
      logic [15:0] rd;
      logic        err;
      int          nbits;
   } exp_t;

   typedef struct {
      logic        rd;
      logic        ch;
      logic [4:0]  phy;
      logic [4:0]  rg;
      logic [15:0] d;
      logic        responds;
      logic [15:0] exp_rd;
      logic        exp_err;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t make_exp(input logic rd, input logic [4:0] phy, input logic [4:0] rg,
                                     input logic [15:0] d, input int pre,
                                     input logic [15:0] erd, input logic eerr);
      exp_t        e;
      logic [31:0] fr;
      fr      = {2'b01, rd ? 2'b10 : 2'b01, phy, rg, 2'b10, d};
      e.out   = '1;
      e.tri_m = '0;
      for (int f = 0; f < 32; f++) begin
         e.out[6'(pre + f)] = fr[5'(31 - f)];
         if (rd && f >= 14) e.tri_m[6'(pre + f)] = 1'b1;
      end
      e.rd    = erd;
      e.err   = eerr;
      e.nbits = pre + 32;
      return e;
   endfunction

   // PHY model: f is the frame bit index (negative during preamble).
   function automatic logic phy_bit(input logic responds, input logic [15:0] d, input int f);
      if (!responds) return 1'b1;
      if (f == 15) return 1'b0;
      if (f >= 16 && f < 32) return d[4'(31 - f)];
      return 1'b1;
   endfunction

   task automatic drive_req(input logic sel, input logic [1:0] op, input logic ch,
                            input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d);
      bus.HOSTMIIMSEL = sel;
      bus.HOSTOPCODE  = op;
      bus.HOSTCHSEL   = ch;
      bus.HOSTADDR    = {phy, rg};
      bus.HOSTWRDATA  = d;
      bus.HOSTREQ     = 1'b1;
      @(negedge clk);
      bus.HOSTREQ     = 1'b0;
   endtask

   task automatic run_frame(input logic rd, input logic ch, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [15:0] d, input logic responds,
                            input logic [15:0] erd, input logic eerr, input logic presup,
                            input int inject_at);
      exp_t        e;
      logic [63:0] cap_out, cap_tri;
      int          low, rises, pre;
      logic        prev_mdc, quiet, done;
      pre = presup ? 0 : PRE;
      sb.push_back(make_exp(rd, phy, rg, d, pre, erd, eerr));
`ifdef TEMAC_MIIM_PRESUP_EN
      bus.HOSTPRESUP = presup;
`endif
      mdin = 2'b11;
      drive_req(1'b1, rd ? 2'b10 : 2'b01, ch, phy, rg, d);
      cap_out = '1; cap_tri = '0;
      low = 0; rises = 0; prev_mdc = 1'b0; quiet = 1'b1; done = 1'b0;
      for (int c = 0; c < 4 * 64 * BIT_CYC && !done; c++) begin
         if (bus.HOSTMIIMRDY === 1'b1) begin
            done = 1'b1;
         end else begin
            low++;
            if (mdc[ch] && !prev_mdc) begin
               if (rises < 64) begin
                  cap_out[6'(rises)] = mdout[ch];
                  cap_tri[6'(rises)] = mdtri[ch];
               end
               rises++;
            end
            prev_mdc = mdc[ch];
            if (mdc[~ch] !== 1'b0 || mdout[~ch] !== 1'b1 || mdtri[~ch] !== 1'b1) quiet = 1'b0;
            mdin[ch] = phy_bit(responds, d, rises - pre);
            if (c == inject_at) begin
               bus.HOSTOPCODE = 2'b01;
               bus.HOSTCHSEL  = ~ch;
               bus.HOSTWRDATA = ~d;
               bus.HOSTREQ    = 1'b1;
            end else begin
               bus.HOSTREQ = 1'b0;
            end
            @(negedge clk);
         end
      end
      bus.HOSTREQ = 1'b0;
      e = sb.pop_front();
      check("frame_done", 64'(done), 64'd1);
      check("rdy_low_cycles", 64'(low), 64'(e.nbits * BIT_CYC));
      check("bit_count", 64'(rises), 64'(e.nbits));
      check("mdout_stream", cap_out | e.tri_m, e.out | e.tri_m);
      check("mdtri_stream", cap_tri, e.tri_m);
      check("rddata", 64'(bus.HOSTRDDATA), 64'(e.rd));
      check("err", 64'(bus.HOSTMIIMERR), 64'(e.err));
      check("idle_port_quiet", 64'(quiet), 64'd1);
   endtask

   task automatic expect_idle(input string name, input int cycles, input logic eerr);
      logic ok;
      ok = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         if (bus.HOSTMIIMRDY !== 1'b1 || mdc !== 2'b00 || mdtri !== 2'b11 ||
             bus.HOSTMIIMERR !== eerr) ok = 1'b0;
         @(negedge clk);
      end
      check(name, 64'(ok), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   low, rises;
      logic prev, ok, done;

      vecs[0] = '{1'b0, 1'b1, 5'd5,  5'h1A, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 5'd1,  5'd2,  16'h1234, 1'b1, 16'h1234, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 5'd1,  5'd2,  16'h1234, 1'b0, 16'hFFFF, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 5'd3,  5'd4,  16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 5'd31, 5'd31, 16'hA5C3, 1'b1, 16'hA5C3, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 5'd0,  5'd0,  16'h0000, 1'b0, 16'hA5C3, 1'b0};

      bus.HOSTREQ = 1'b0; bus.HOSTMIIMSEL = 1'b0; bus.HOSTOPCODE = 2'b00;
      bus.HOSTADDR = '0; bus.HOSTCHSEL = '0; bus.HOSTWRDATA = '0;
      bus3.HOSTREQ = 1'b0; bus3.HOSTMIIMSEL = 1'b0; bus3.HOSTOPCODE = 2'b00;
      bus3.HOSTADDR = '0; bus3.HOSTCHSEL = '0; bus3.HOSTWRDATA = '0;
`ifdef TEMAC_MIIM_PRESUP_EN
      bus.HOSTPRESUP = 1'b0;
      bus3.HOSTPRESUP = 1'b0;
`endif

      repeat (3) @(negedge clk);
      check("reset_rdy", 64'(bus.HOSTMIIMRDY), 64'd1);
      check("reset_rddata", 64'(bus.HOSTRDDATA), 64'd0);
      check("reset_err", 64'(bus.HOSTMIIMERR), 64'd0);
      check("reset_phy_pins", {58'd0, mdc, mdout, mdtri}, {58'd0, 2'b00, 2'b11, 2'b11});
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++)
         run_frame(vecs[i].rd, vecs[i].ch, vecs[i].phy, vecs[i].rg, vecs[i].d,
                   vecs[i].responds, vecs[i].exp_rd, vecs[i].exp_err, 1'b0, -1);

      drive_req(1'b1, 2'b00, 1'b0, 5'd1, 5'd1, 16'h1111);
      expect_idle("opcode00_ignored", 40, 1'b0);
      drive_req(1'b1, 2'b11, 1'b1, 5'd1, 5'd1, 16'h1111);
      expect_idle("opcode11_ignored", 40, 1'b0);
      drive_req(1'b0, 2'b01, 1'b0, 5'd1, 5'd1, 16'h1111);
      expect_idle("miimsel_low_ignored", 40, 1'b0);

      run_frame(1'b0, 1'b0, 5'd9, 5'd17, 16'hC0DE, 1'b0, 16'hA5C3, 1'b0, 1'b0, 100);
      expect_idle("busy_req_no_extra_frame", 40, 1'b0);

      // Out-of-range channel, then the highest legal channel on the 3-port build.
      bus3.HOSTMIIMSEL = 1'b1; bus3.HOSTOPCODE = 2'b01; bus3.HOSTCHSEL = 2'd3;
      bus3.HOSTADDR = {5'd2, 5'd3}; bus3.HOSTWRDATA = 16'h4321; bus3.HOSTREQ = 1'b1;
      @(negedge clk);
      bus3.HOSTREQ = 1'b0;
      check("chsel_oob_err", 64'(bus3.HOSTMIIMERR), 64'd1);
      ok = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (bus3.HOSTMIIMRDY !== 1'b1 || mdc3 !== 3'b000) ok = 1'b0;
         @(negedge clk);
      end
      check("chsel_oob_no_frame", 64'(ok), 64'd1);
      bus3.HOSTCHSEL = 2'd2; bus3.HOSTREQ = 1'b1;
      @(negedge clk);
      bus3.HOSTREQ = 1'b0;
      check("chsel_ok_err_cleared", 64'(bus3.HOSTMIIMERR), 64'd0);
      low = 0; rises = 0; prev = 1'b0; ok = 1'b1; done = 1'b0;
      for (int c = 0; c < 2000 && !done; c++) begin
         if (bus3.HOSTMIIMRDY === 1'b1) begin
            done = 1'b1;
         end else begin
            low++;
            if (mdc3[2] && !prev) rises++;
            prev = mdc3[2];
            if (mdc3[1:0] !== 2'b00 || mdout3[1:0] !== 2'b11 || mdtri3[1:0] !== 2'b11) ok = 1'b0;
            @(negedge clk);
         end
      end
      check("ch2_rdy_low_cycles", 64'(low), 64'(33 * 4));
      check("ch2_bit_count", 64'(rises), 64'd33);
      check("ch2_other_ports_quiet", 64'(ok), 64'd1);

      // Reset during the high phase of bit 40 of a write.
      mdin = 2'b11;
      drive_req(1'b1, 2'b01, 1'b0, 5'd7, 5'd9, 16'h1357);
      rises = 0; prev = 1'b0;
      for (int c = 0; c < 64 * BIT_CYC && rises < 41; c++) begin
         if (mdc[0] && !prev) rises++;
         prev = mdc[0];
         if (rises < 41) @(negedge clk);
      end
      check("reached_bit40", 64'(rises), 64'd41);
      rst = 1'b1;
      #1;
      check("midframe_reset_pins", {58'd0, mdc, mdout, mdtri}, {58'd0, 2'b00, 2'b11, 2'b11});
      check("midframe_reset_rdy", 64'(bus.HOSTMIIMRDY), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      expect_idle("post_reset_no_completion", 10, 1'b0);
      check("post_reset_rddata", 64'(bus.HOSTRDDATA), 64'd0);
      run_frame(1'b0, 1'b1, 5'd4, 5'd8, 16'h8001, 1'b0, 16'h0000, 1'b0, 1'b0, -1);

`ifdef TEMAC_MIIM_PRESUP_EN
      run_frame(1'b0, 1'b0, 5'd6, 5'd12, 16'h0F0F, 1'b0, 16'h0000, 1'b0, 1'b1, -1);
      bus.HOSTPRESUP = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
